// File: rtl/sayeh_pkg.sv
// Shared definitions for the SAYEH fetch path: FSM encoding and default constants.
package sayeh_pkg;

    // Fetch FSM states
    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StReq    = 3'd1,
        StLoad   = 3'd2,
        StHalted = 3'd3,
        StError  = 3'd4
    } fetch_state_e;

    localparam logic [15:0] DEF_RESET_PC = 16'h0000;
    localparam int unsigned DEF_WAIT_MAX = 15;

    // Width of the wait counter; covers WAIT_MAX up to 255
    localparam int unsigned WAIT_CNT_W = 8;

endpackage

// File: rtl/fetch_timeout_counter.sv
// Counts REQ cycles spent waiting for mem_ready; flags the cycle whose increment reaches WAIT_MAX.
module fetch_timeout_counter
    import sayeh_pkg::*;
#(
    parameter int unsigned WAIT_MAX = DEF_WAIT_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [WAIT_CNT_W-1:0] count_q;
    logic [WAIT_CNT_W-1:0] count_d;

    // Next count: clear wins over enable
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Expires on the increment that would reach WAIT_MAX, so a read completing at WAIT_MAX-1 wins
    always_comb begin
        expired = enable && !clear && (count_q == WAIT_CNT_W'(WAIT_MAX - 1));
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: holds the PC, issues a memory read per fetch request and pulses
// IRload with the fetched word; traps to ERROR when memory fails to answer in time.
module instruction_fetch_unit
    import sayeh_pkg::*;
#(
    parameter logic [15:0] RESET_PC = DEF_RESET_PC,
    parameter int unsigned WAIT_MAX = DEF_WAIT_MAX
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    input  logic        jump_en,
    input  logic [15:0] jump_addr,
    input  logic        halt,
    input  logic [15:0] mem_data,
    input  logic        mem_ready,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    output logic [15:0] ir_data,
    output logic        IRload,
    output logic [15:0] pc_out,
    output logic        busy,
    output logic        mem_error
);

    fetch_state_e state_q;
    fetch_state_e state_d;
    logic [15:0]  pc_q;
    logic [15:0]  pc_d;
    logic [15:0]  ir_q;
    logic [15:0]  ir_d;
    logic         cnt_clear;
    logic         cnt_enable;
    logic         cnt_expired;

    fetch_timeout_counter #(
        .WAIT_MAX (WAIT_MAX)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (cnt_clear),
        .enable  (cnt_enable),
        .expired (cnt_expired)
    );

    // Next-state, PC and IR update logic; control inputs only matter in IDLE
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        cnt_clear  = 1'b0;
        cnt_enable = 1'b0;
        case (state_q)
            StIdle: begin
                if (halt) begin
                    state_d = StHalted;
                end else if (jump_en) begin
                    pc_d = jump_addr;
                end else if (fetch_en) begin
                    state_d   = StReq;
                    cnt_clear = 1'b1;
                end
            end
            StReq: begin
                if (mem_ready) begin
                    ir_d    = mem_data;
                    state_d = StLoad;
                end else begin
                    cnt_enable = 1'b1;
                    if (cnt_expired) begin
                        state_d = StError;
                    end
                end
            end
            StLoad: begin
                pc_d    = pc_q + 16'd1;
                state_d = StIdle;
            end
            StHalted, StError: begin
                state_d = state_q;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, PC and instruction registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Outputs decode only registered state, so they change cleanly after the clock edge
    always_comb begin
        mem_rd    = (state_q == StReq);
        IRload    = (state_q == StLoad);
        busy      = (state_q == StReq) || (state_q == StLoad);
        mem_error = (state_q == StError);
        mem_addr  = pc_q;
        pc_out    = pc_q;
        ir_data   = ir_q;
    end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000: program counter value loaded by reset.
REQ-002 Parameter WAIT_MAX, default 15: maximum number of cycles a read may wait for mem_ready before an error; range 1..255.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 fetch_en  input  1  controller request to fetch the next instruction.
REQ-006 jump_en  input  1  load PC from jump_addr.
REQ-007 jump_addr  input  16  jump target.
REQ-008 halt  input  1  stop fetching.
REQ-009 mem_data  input  16  instruction word from memory.
REQ-010 mem_ready  input  1  memory read-data valid.
REQ-011 mem_addr  output  16  memory read address.
REQ-012 mem_rd  output  1  memory read strobe.
REQ-013 ir_data  output  16  instruction word to the instruction register data input.
REQ-014 IRload  output  1  instruction register load enable.
REQ-015 pc_out  output  16  current program counter.
REQ-016 busy  output  1  fetch in progress.
REQ-017 mem_error  output  1  sticky read-timeout flag.

Function
REQ-018 The FSM SHALL have exactly the states IDLE, REQ, LOAD, HALTED and ERROR.
REQ-019 In IDLE with halt=1, the FSM SHALL go to HALTED; halt SHALL take priority over jump_en and fetch_en.
REQ-020 In IDLE with halt=0 and jump_en=1, PC SHALL be loaded with jump_addr and the FSM SHALL stay in IDLE; a simultaneous fetch_en SHALL be ignored.
REQ-021 In IDLE with halt=0, jump_en=0 and fetch_en=1, the FSM SHALL go to REQ and clear the wait counter.
REQ-022 In REQ, mem_rd SHALL be 1 and mem_addr SHALL equal PC throughout.
REQ-023 In REQ with mem_ready=1, mem_data SHALL be registered into ir_data and the FSM SHALL go to LOAD.
REQ-024 In REQ with mem_ready=0, the wait counter SHALL increment; when it reaches WAIT_MAX, the FSM SHALL go to ERROR and set mem_error.
REQ-025 A read that completes at wait count WAIT_MAX-1 SHALL succeed.
REQ-026 In LOAD, IRload SHALL be 1 for exactly one cycle with ir_data stable, PC SHALL increment by 1 modulo 2^16 (16'hFFFF wraps to 16'h0000), and the FSM SHALL return to IDLE.
REQ-027 ir_data SHALL hold its value in all states other than REQ and the REQ-to-LOAD transition, so that a falling-edge-sampling register captures it within the same cycle.
REQ-028 Latency from fetch_en in IDLE to IRload SHALL be 2 cycles plus the number of cycles mem_ready is low in REQ.
REQ-029 jump_en, halt and fetch_en SHALL be ignored in REQ and LOAD.
REQ-030 HALTED and ERROR SHALL be terminal until rst; mem_rd and IRload SHALL be 0 in both states.
REQ-031 busy SHALL be 1 exactly in REQ and LOAD.
REQ-032 mem_addr SHALL equal PC when not in REQ.
REQ-033 pc_out SHALL equal PC at all times.
REQ-034 mem_error SHALL be 1 exactly in ERROR.

Reset
REQ-035 On rst=1 at a clock edge, all of the following SHALL apply:
- PC SHALL become RESET_PC.
- The FSM SHALL go to IDLE.
- The wait counter, ir_data, IRload, mem_rd, busy and mem_error SHALL become 0.
REQ-036 rst SHALL override every other input in every state, including mid-REQ, where mem_rd SHALL be 0 from the cycle after the reset edge.

Structure
REQ-037 The FSM state encoding and the default constants RESET_PC and WAIT_MAX SHALL reside in the shared package sayeh_pkg.
REQ-038 The wait counter SHALL be a sub-module, fetch_timeout_counter, with inputs clear and enable, and output expired.
REQ-039 The rest of the block SHALL be flat RTL with registered outputs.

Verification
REQ-040 The bench SHALL cover each scenario below.
- Fetch after reset: rst, then fetch_en with mem_ready=1 one cycle after mem_rd and mem_data=16'h1234 -> mem_addr=16'h0000, IRload pulse with ir_data=16'h1234, pc_out=16'h0001.
- Wait states: mem_ready held low for 3 cycles -> IRload arrives 5 cycles after fetch_en, mem_addr stable throughout.
- Jump then fetch: jump_en with jump_addr=16'hFFFF, then fetch -> mem_addr=16'hFFFF, pc_out=16'h0000 after LOAD.
- Priority: halt=1, jump_en=1 and fetch_en=1 in the same IDLE cycle -> HALTED, PC unchanged, no mem_rd; only rst recovers.
- Timeout: mem_ready never asserted with WAIT_MAX=15 -> mem_error=1 after 15 REQ cycles, mem_rd=0; a response at cycle 14 SHALL succeed instead.
- Reset mid-REQ: rst during REQ -> mem_rd=0 and pc_out=RESET_PC the next cycle, no IRload.
